vid_timing_ctrl: RTL and testbench
==================================

VID_TIMING_CTRL -- requirements
Module: vid_timing_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameters H_FRONT_PORCH, H_SYNC_WIDTH and H_BACK_PORCH, defaults 16, 96 and 48, horizontal blanking intervals in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-004 SHALL have parameters V_FRONT_PORCH, V_SYNC_WIDTH and V_BACK_PORCH, defaults 10, 2 and 33, vertical blanking intervals in lines.
REQ-005 SHALL derive local H_FRAME (sum of all H terms, 800 by default) and V_FRAME (sum of all V terms, 525 by default).
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: run request, sampled each cycle.
REQ-009 SHALL have port stop, input, 1 bit: stop request, sampled each cycle.
REQ-010 SHALL have port busy, output, 1 bit: high in RUN and DRAIN.
REQ-011 SHALL have port out_hcnt, output, $clog2(H_FRAME) bits: pixel position within the line.
REQ-012 SHALL have port out_vcnt, output, $clog2(V_FRAME) bits: line position within the frame.
REQ-013 SHALL have port out_de, output, 1 bit: active-video flag.
REQ-014 SHALL have port out_frame_start, output, 1 bit: pulse on pixel (0,0).
REQ-015 SHALL have port out_frame_end, output, 1 bit: pulse on the last pixel of a frame.
REQ-016 SHALL have port out_frame_cnt, output, 32 bits: completed-frame count; present only under the configuration macro.

Function
REQ-017 SHALL implement FSM IDLE/RUN/DRAIN: IDLE->RUN on start&!stop; RUN->DRAIN on stop; DRAIN->RUN on start&!stop; DRAIN->IDLE on last pixel (hcnt=H_FRAME-1, vcnt=V_FRAME-1); all other combinations hold state.
REQ-018 SHALL, on start sampled in IDLE at cycle n, present busy=1, hcnt=0, vcnt=0 and frame_start=1 at cycle n+1.
REQ-019 SHALL, in RUN/DRAIN, increment hcnt every cycle, wrapping H_FRAME-1->0; vcnt SHALL increment only on hcnt wrap and wrap V_FRAME-1->0.
REQ-020 SHALL hold hcnt=vcnt=0 in IDLE, and SHALL return both counters to 0 in the same cycle the FSM enters IDLE.
REQ-021 SHALL register out_de, aligned with the counters: de=busy&(hcnt<H_ACTIVE)&(vcnt<V_ACTIVE).
REQ-022 SHALL register out_frame_start and out_frame_end, aligned with the counters and qualified by busy.
REQ-023 SHALL complete the current frame when stop is issued mid-frame; frame_end SHALL pulse on that frame's last pixel, and busy SHALL fall on the following cycle.
REQ-024 SHALL treat start in DRAIN as cancelling the pending stop without disturbing the counters.
REQ-025 SHALL ignore stop in IDLE and start in RUN.

Reset
REQ-026 SHALL, on rst assertion, immediately force state IDLE and all outputs to 0, including busy, counters, de, the pulses and frame_cnt, regardless of operation in progress.
REQ-027 SHALL resume with the first sampled start after rst deassertion; no request seen during reset is retained.

Configuration
REQ-028 SHALL, with macro VID_TIMING_CTRL_FRAME_CNT_EN defined, provide out_frame_cnt, incremented on each frame_end, wrapping 0xFFFFFFFF->0, and cleared only by rst.
REQ-029 SHALL, without VID_TIMING_CTRL_FRAME_CNT_EN, omit the port and the counter, leaving all other behaviour identical.

Structure
REQ-030 SHALL place the FSM state enum and a timing struct (eight H/V interval fields) in shared package vid_pkg.
REQ-031 SHALL implement the hcnt/vcnt pair with its wrap logic in sub-module vid_hv_counter (inputs: enable, clear).

Verification (bench params H=4/1/1/2, V=3/1/1/1 -> H_FRAME=8, V_FRAME=6)
REQ-032 SHALL check: start pulse at cycle 10 -> cycle 11 shows busy=1, hcnt=0, vcnt=0, frame_start=1, de=1; cycle 15 shows de=0 (hcnt=4).
REQ-033 SHALL check: free run of 48 cycles -> hcnt 7->0 and vcnt 5->0 wraps, frame_end on (7,5), frame_start on the next cycle.
REQ-034 SHALL check: stop at (2,1) -> counting continues to (7,5), frame_end=1, next cycle busy=0 with counters 0.
REQ-035 SHALL check: stop at (2,1) then start at (5,3) -> no drop to IDLE, counting is continuous, busy stays 1.
REQ-036 SHALL check: rst asserted at (3,2) -> outputs are 0 asynchronously; start&stop together in IDLE -> stays IDLE.
REQ-037 SHALL check, with VID_TIMING_CTRL_FRAME_CNT_EN defined: 3 full frames -> frame_cnt=3; stop/start leaves it unchanged; rst clears it to 0.

Source files
------------

// File: rtl/vid_pkg.sv
// Shared types for the video timing controller.
// Contents: FSM state enum, timing struct (eight H/V interval fields), frame-size helpers.
package vid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } vid_state_e;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_front_porch;
    logic [15:0] h_sync_width;
    logic [15:0] h_back_porch;
    logic [15:0] v_active;
    logic [15:0] v_front_porch;
    logic [15:0] v_sync_width;
    logic [15:0] v_back_porch;
  } vid_timing_t;

  localparam vid_timing_t VID_TIMING_DEFAULT = '{
    h_active: 16'd640, h_front_porch: 16'd16, h_sync_width: 16'd96, h_back_porch: 16'd48,
    v_active: 16'd480, v_front_porch: 16'd10, v_sync_width: 16'd2,  v_back_porch: 16'd33
  };

  // Total pixels per line.
  function automatic int unsigned h_total(input vid_timing_t t);
    return 32'(t.h_active) + 32'(t.h_front_porch) + 32'(t.h_sync_width) + 32'(t.h_back_porch);
  endfunction

  // Total lines per frame.
  function automatic int unsigned v_total(input vid_timing_t t);
    return 32'(t.v_active) + 32'(t.v_front_porch) + 32'(t.v_sync_width) + 32'(t.v_back_porch);
  endfunction

endpackage

// File: rtl/vid_hv_counter.sv
// Pixel/line position counter pair with frame wrap.
// Ports: clk, rst (async, active-high), enable (advance one pixel), clear (force to 0),
//        hcnt/vcnt (registered position), hcnt_nxt_c/vcnt_nxt_c (position after this edge).
module vid_hv_counter
  import vid_pkg::*;
#(
  parameter vid_timing_t TIMING = VID_TIMING_DEFAULT,
  localparam int unsigned H_FRAME = h_total(TIMING),
  localparam int unsigned V_FRAME = v_total(TIMING),
  localparam int unsigned HW = $clog2(H_FRAME),
  localparam int unsigned VW = $clog2(V_FRAME)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          clear,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic [HW-1:0] hcnt_nxt_c,
  output logic [VW-1:0] vcnt_nxt_c
);

  localparam logic [HW-1:0] H_LAST = HW'(H_FRAME - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_FRAME - 1);

  // Next position: clear wins, else advance with line/frame wrap.
  always_comb begin
    hcnt_nxt_c = hcnt;
    vcnt_nxt_c = vcnt;
    if (clear) begin
      hcnt_nxt_c = '0;
      vcnt_nxt_c = '0;
    end else if (enable) begin
      if (hcnt == H_LAST) begin
        hcnt_nxt_c = '0;
        vcnt_nxt_c = (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
      end else begin
        hcnt_nxt_c = hcnt + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= hcnt_nxt_c;
      vcnt <= vcnt_nxt_c;
    end
  end

endmodule

// File: rtl/vid_timing_ctrl.sv
// Video timing controller: IDLE/RUN/DRAIN sequencer driving a raster position counter,
// with registered active-video and frame start/end flags aligned to the counters.
// Ports: clk, rst (async, active-high), start, stop, busy, out_hcnt, out_vcnt, out_de,
//        out_frame_start, out_frame_end, out_frame_cnt (only with VID_TIMING_CTRL_FRAME_CNT_EN).
// Macro VID_TIMING_CTRL_FRAME_CNT_EN adds a 32-bit completed-frame counter.
module vid_timing_ctrl
  import vid_pkg::*;
#(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned H_FRONT_PORCH = 16,
  parameter int unsigned H_SYNC_WIDTH  = 96,
  parameter int unsigned H_BACK_PORCH  = 48,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned V_FRONT_PORCH = 10,
  parameter int unsigned V_SYNC_WIDTH  = 2,
  parameter int unsigned V_BACK_PORCH  = 33,
  localparam int unsigned H_FRAME = H_ACTIVE + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH,
  localparam int unsigned V_FRAME = V_ACTIVE + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH,
  localparam int unsigned HW = $clog2(H_FRAME),
  localparam int unsigned VW = $clog2(V_FRAME)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  output logic          busy,
  output logic [HW-1:0] out_hcnt,
  output logic [VW-1:0] out_vcnt,
  output logic          out_de,
  output logic          out_frame_start,
  output logic          out_frame_end
`ifdef VID_TIMING_CTRL_FRAME_CNT_EN
  ,
  output logic [31:0]   out_frame_cnt
`endif
);

  localparam vid_timing_t TIMING = '{
    h_active: 16'(H_ACTIVE), h_front_porch: 16'(H_FRONT_PORCH),
    h_sync_width: 16'(H_SYNC_WIDTH), h_back_porch: 16'(H_BACK_PORCH),
    v_active: 16'(V_ACTIVE), v_front_porch: 16'(V_FRONT_PORCH),
    v_sync_width: 16'(V_SYNC_WIDTH), v_back_porch: 16'(V_BACK_PORCH)
  };
  localparam logic [HW-1:0] H_LAST = HW'(H_FRAME - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_FRAME - 1);

  vid_state_e    state, state_nxt;
  logic          last_pix;
  logic          busy_nxt;
  logic [HW-1:0] hcnt_nxt;
  logic [VW-1:0] vcnt_nxt;

  assign last_pix = (out_hcnt == H_LAST) && (out_vcnt == V_LAST);

  // Counters advance whenever a frame is in flight; cleared on the way into IDLE.
  vid_hv_counter #(.TIMING(TIMING)) u_hv (
    .clk        (clk),
    .rst        (rst),
    .enable     (state != ST_IDLE),
    .clear      (state_nxt == ST_IDLE),
    .hcnt       (out_hcnt),
    .vcnt       (out_vcnt),
    .hcnt_nxt_c (hcnt_nxt),
    .vcnt_nxt_c (vcnt_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Start cancels a pending drain; a drain only ends on the frame's last pixel.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start && !stop) state_nxt = ST_RUN;
      ST_RUN:   if (stop) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (start && !stop) state_nxt = ST_RUN;
        else if (last_pix)  state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign busy_nxt = (state_nxt != ST_IDLE);

  // Flags are computed from next-cycle position so they line up with the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy            <= 1'b0;
      out_de          <= 1'b0;
      out_frame_start <= 1'b0;
      out_frame_end   <= 1'b0;
    end else begin
      busy            <= busy_nxt;
      out_de          <= busy_nxt && ({1'b0, hcnt_nxt} < (HW+1)'(H_ACTIVE))
                                  && ({1'b0, vcnt_nxt} < (VW+1)'(V_ACTIVE));
      out_frame_start <= busy_nxt && (hcnt_nxt == '0) && (vcnt_nxt == '0);
      out_frame_end   <= busy_nxt && (hcnt_nxt == H_LAST) && (vcnt_nxt == V_LAST);
    end
  end

`ifdef VID_TIMING_CTRL_FRAME_CNT_EN
  // Completed frames; counts once a frame_end pixel has been presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                out_frame_cnt <= '0;
    else if (out_frame_end) out_frame_cnt <= out_frame_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_vid_timing_ctrl.sv
// Directed bench for vid_timing_ctrl at a tiny 8x6 raster, with a queue scoreboard.
module tb_vid_timing_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       busy;
  logic [2:0] out_hcnt;
  logic [2:0] out_vcnt;
  logic       out_de;
  logic       out_frame_start;
  logic       out_frame_end;
  logic [31:0] frame_cnt_obs;
`ifdef VID_TIMING_CTRL_FRAME_CNT_EN
  logic [31:0] out_frame_cnt;
  assign frame_cnt_obs = out_frame_cnt;
`else
  assign frame_cnt_obs = 32'd0;
`endif

  vid_timing_ctrl #(
    .H_ACTIVE(4), .H_FRONT_PORCH(1), .H_SYNC_WIDTH(1), .H_BACK_PORCH(2),
    .V_ACTIVE(3), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(1), .V_BACK_PORCH(1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .stop            (stop),
    .busy            (busy),
    .out_hcnt        (out_hcnt),
    .out_vcnt        (out_vcnt),
    .out_de          (out_de),
    .out_frame_start (out_frame_start),
    .out_frame_end   (out_frame_end)
`ifdef VID_TIMING_CTRL_FRAME_CNT_EN
    ,
    .out_frame_cnt   (out_frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        busy;
    logic [2:0]  h;
    logic [2:0]  v;
    logic        de;
    logic        fs;
    logic        fe;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model of the raster sequencer (8 pixels x 6 lines, 4x3 active).
  logic        m_busy, m_drain, m_fe;
  int          m_h, m_v;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_drain = 1'b0; m_fe = 1'b0; m_h = 0; m_v = 0; m_cnt = 32'd0;
  endtask

  task automatic model_step(input logic s, input logic p);
    logic at_end;
    if (m_fe) m_cnt = m_cnt + 32'd1;
    if (!m_busy) begin
      if (s && !p) begin
        m_busy = 1'b1; m_drain = 1'b0; m_h = 0; m_v = 0;
      end
    end else begin
      at_end = (m_h == 7) && (m_v == 5);
      if (m_drain && s && !p)      m_drain = 1'b0;
      else if (m_drain && at_end)  m_busy = 1'b0;
      else if (!m_drain && p)      m_drain = 1'b1;
      if (!m_busy) begin
        m_h = 0; m_v = 0;
      end else begin
        m_h = (m_h + 1) % 8;
        if (m_h == 0) m_v = (m_v + 1) % 6;
      end
    end
    m_fe = m_busy && (m_h == 7) && (m_v == 5);
  endtask

  task automatic check_outputs(input exp_t e);
    chk("busy",  32'(busy),            32'(e.busy));
    chk("hcnt",  32'(out_hcnt),        32'(e.h));
    chk("vcnt",  32'(out_vcnt),        32'(e.v));
    chk("de",    32'(out_de),          32'(e.de));
    chk("fstart",32'(out_frame_start), 32'(e.fs));
    chk("fend",  32'(out_frame_end),   32'(e.fe));
`ifdef VID_TIMING_CTRL_FRAME_CNT_EN
    chk("fcnt",  frame_cnt_obs,        e.cnt);
`endif
  endtask

  // One clock: drive at the falling edge, predict, compare at the next falling edge.
  task automatic cyc(input logic s, input logic p);
    exp_t e;
    start = s;
    stop  = p;
    model_step(s, p);
    e.busy = m_busy;
    e.h    = 3'(m_h);
    e.v    = 3'(m_v);
    e.de   = m_busy && (m_h < 4) && (m_v < 3);
    e.fs   = m_busy && (m_h == 0) && (m_v == 0);
    e.fe   = m_fe;
    e.cnt  = m_cnt;
    q.push_back(e);
    @(negedge clk);
    e = q.pop_front();
    check_outputs(e);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic goto_pos(input int h, input int v);
    int n = 0;
    while (!(m_busy && m_h == h && m_v == v)) begin
      if (n >= 100) begin
        total++;
        bad++;
        $error("FAIL goto_timeout observed=(%0d,%0d) expected=(%0d,%0d)", m_h, m_v, h, v);
        return;
      end
      cyc(1'b0, 1'b0);
      n++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy),            32'd0);
    chk({tag, "_hcnt"}, 32'(out_hcnt),        32'd0);
    chk({tag, "_vcnt"}, 32'(out_vcnt),        32'd0);
    chk({tag, "_de"},   32'(out_de),          32'd0);
    chk({tag, "_fs"},   32'(out_frame_start), 32'd0);
    chk({tag, "_fe"},   32'(out_frame_end),   32'd0);
`ifdef VID_TIMING_CTRL_FRAME_CNT_EN
    chk({tag, "_fcnt"}, frame_cnt_obs,        32'd0);
`endif
  endtask

  initial begin
    int fe_seen;
    int fs_seen;
    logic busy_dropped;
    logic [31:0] cnt_snap;

    rst = 1'b1; start = 1'b0; stop = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Idle cycles; stop alone in IDLE is ignored.
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("idle_stop_busy", 32'(busy), 32'd0);

    // Start: first pixel of a frame next cycle.
    cyc(1'b1, 1'b0);
    chk("start_busy", 32'(busy),            32'd1);
    chk("start_h",    32'(out_hcnt),        32'd0);
    chk("start_v",    32'(out_vcnt),        32'd0);
    chk("start_fs",   32'(out_frame_start), 32'd1);
    chk("start_de",   32'(out_de),          32'd1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
    chk("blank_h",    32'(out_hcnt),        32'd4);
    chk("blank_de",   32'(out_de),          32'd0);
    cyc(1'b1, 1'b0);
    chk("run_start_ignored_h", 32'(out_hcnt), 32'd5);

    // Free run of one full frame: exactly one frame_end then one frame_start.
    fe_seen = 0;
    fs_seen = 0;
    for (int i = 0; i < 48; i++) begin
      cyc(1'b0, 1'b0);
      if (out_frame_end) begin
        fe_seen++;
        chk("fe_pos", {26'd0, out_vcnt, out_hcnt}, {26'd0, 3'd5, 3'd7});
      end
      if (out_frame_start) fs_seen++;
    end
    chk("freerun_fe_count", 32'(fe_seen), 32'd1);
    chk("freerun_fs_count", 32'(fs_seen), 32'd1);

    // Stop mid-frame: finish the frame, then drop to IDLE with counters cleared.
    goto_pos(2, 1);
    cyc(1'b0, 1'b1);
    goto_pos(7, 5);
    chk("drain_fe", 32'(out_frame_end), 32'd1);
    cyc(1'b0, 1'b0);
    chk("drain_idle_busy", 32'(busy),     32'd0);
    chk("drain_idle_h",    32'(out_hcnt), 32'd0);
    chk("drain_idle_v",    32'(out_vcnt), 32'd0);

    // Stop then start while draining: no drop to IDLE.
    cyc(1'b1, 1'b0);
    goto_pos(2, 1);
    cyc(1'b0, 1'b1);
    goto_pos(5, 3);
    cnt_snap = frame_cnt_obs;
    cyc(1'b1, 1'b0);
    chk("cancel_h", 32'(out_hcnt), 32'd6);
    chk("cancel_cnt_unchanged", frame_cnt_obs, cnt_snap);
    busy_dropped = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cyc(1'b0, 1'b0);
      if (!busy) busy_dropped = 1'b1;
    end
    chk("cancel_busy_held", 32'(busy_dropped), 32'd0);

    // Asynchronous reset mid-frame.
    goto_pos(3, 2);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    cyc(1'b0, 1'b0);
    chk("rst_no_retain", 32'(busy), 32'd0);
    cyc(1'b1, 1'b1);
    chk("start_stop_idle", 32'(busy), 32'd0);

    // Three full frames from reset, then stop/start, then reset.
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 144; i++) cyc(1'b0, 1'b0);
`ifdef VID_TIMING_CTRL_FRAME_CNT_EN
    chk("three_frames_cnt", frame_cnt_obs, 32'd3);
`endif
    goto_pos(2, 1);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
`ifdef VID_TIMING_CTRL_FRAME_CNT_EN
    chk("stopstart_cnt", frame_cnt_obs, 32'd3);
`endif
    chk("stopstart_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("final_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
